snake_matrix_scan: RTL and testbench
====================================

# snake_matrix_scan

Display-side consumer of the snake game controller. Snapshots the controller's snake/food/status outputs once per frame, builds each row bitmap serially, and drives an 8x8 LED matrix by time-multiplexed row scanning. Sits between `snake_ctl` and the board's matrix row/column pins.

## Interface

- `ROW_TICKS`, 1000: cycles each row is lit; must be ≥ 12.
- `FOOD_BLINK_LOG2`, 4: food toggles visibility every 2^FOOD_BLINK_LOG2 frames; must be ≥ 1.

- `clkn`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `display`  in  1  1 = matrix enabled; 0 = all LEDs off, scan timing continues.
- `draw_start`, `draw_over`, `draw_win`  in  1 each  overlay requests from controller.
- `snake_len`  in  5  live segment count; values > 10 are treated as 10.
- `snake_0` … `snake_9`  in  8 each  segment coordinates; [7:4] = row, [3:0] = column; a field > 7 means off-matrix and is not drawn.
- `food`  in  8  food coordinate, same encoding.
- `row_n`  out  8  one-hot active-low row select.
- `col`  out  8  active-high column data; bit c = column c.
- `frame_done`  out  1  one-cycle pulse at the end of row 7.

## Operation

- States: SNAP → BUILD → SHOW → (BUILD of next row | SNAP after row 7).
- SNAP (1 cycle):
  - Register all inputs into shadow copies: `len_s` (saturated to 10), `seg_s[0..9]`, `food_s`, overlay flags, `display`.
  - Set row = 0.
- BUILD (11 cycles, index k = 0..10):
  - k < 10: OR bit `seg_s[k][3:0]` into the accumulator when k < `len_s` and the row field of `seg_s[k]` equals the current row.
  - k = 10: OR in the food bit when its row matches and the blink phase is visible.
  - Accumulator is cleared on BUILD entry.
- SHOW (ROW_TICKS cycles):
  - `row_n` = ~(1 << row).
  - `col` = accumulator, or the overlay pattern.
  - At the end of row 7: pulse `frame_done`, increment the frame counter, go to SNAP. Otherwise row+1 and go to BUILD.
- Overlay priority: win > over > start > normal.
  - win: `col` = 8'hFF on every row.
  - over: `col` = (1<<row) | (1<<(7-row)), an X pattern.
  - start: rows 0 and 7 = 8'hFF, other rows = 8'h81 (border).
  - Overlays use identical state timing; the BUILD result is ignored.
- Food blink: frame counter is FOOD_BLINK_LOG2+1 bits. Food is visible while its MSB = 0.
- Shadowed `display` = 0: `row_n` = 8'hFF and `col` = 8'h00 throughout the frame.
- Duplicate coordinates OR harmlessly. Off-matrix coordinates never light anything.

## Timing

- Reset values: state = SNAP, row = 0, frame counter = 0, `row_n` = 8'hFF, `col` = 8'h00, `frame_done` = 0.
- During SNAP and BUILD: `row_n` = 8'hFF and `col` = 8'h00 (ghost-free blanking).
- Row period = 11 + ROW_TICKS cycles. Frame period = 1 + 8·(11 + ROW_TICKS).
- `frame_done` is high on the first SNAP cycle after row 7's last SHOW cycle.
- Inputs are sampled only in SNAP. Mid-frame input changes take effect next frame (no tearing).
- All outputs are registered. SHOW values appear on the first SHOW cycle.
- Reset mid-frame: immediate return to reset values; first SNAP on the first edge after deassertion.

## Structure

- Shared package `snake_pkg`:
  - `N_SEG` = 10, `MATRIX_DIM` = 8.
  - Coordinate field slices (row [7:4], column [3:0]).
  - Overlay pattern constants.
  - State enum (SNAP/BUILD/SHOW).
- Sub-module `snake_row_builder`: the serial 11-step OR-accumulator (inputs: row, index, shadowed segment/food/len; output: 8-bit bitmap).
- Top level holds the FSM, tick counter, row counter, frame counter and output registers.

## Test plan

All scenarios use ROW_TICKS = 20 (frame = 249 cycles).

- Reset, then idle with `display` = 0 → `row_n` = 8'hFF and `col` = 0 throughout; `frame_done` pulses every 249 cycles; first pulse 249 cycles after reset release.
- `display` = 1, `snake_len` = 3, segments 8'h22, 8'h23, 8'h24, `food` = 8'h55 → row 2 shows `col` = 8'h1C; row 5 shows 8'h20 for frames 0–15 and 8'h00 for frames 16–31.
- `snake_len` = 2 with `snake_2` = 8'h22 → segment 2 not drawn. `snake_len` = 31 → all 10 segments drawn. Segment 8'h88 → nothing lit.
- `draw_over` = 1 with `draw_win` = 1 → every row shows 8'hFF. `draw_over` alone → row 3 shows 8'h18, row 0 shows 8'h81.
- Change `snake_0` from 8'h00 to 8'h70 during row 4 → current frame still lights (0,0); next frame lights (7,0) only.
- Assert `reset` during row 5 SHOW → outputs return to 8'hFF/8'h00 asynchronously; scan restarts at row 0 after release.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, coordinate helpers and scan state type for the snake display
package snake_pkg;

  localparam int N_SEG       = 10;
  localparam int MATRIX_DIM  = 8;
  localparam int BUILD_STEPS = N_SEG + 1;

  localparam logic [7:0] PAT_WIN         = 8'hFF;
  localparam logic [7:0] PAT_BORDER_EDGE = 8'hFF;
  localparam logic [7:0] PAT_BORDER_SIDE = 8'h81;

  typedef enum logic [1:0] {
    ST_SNAP,
    ST_BUILD,
    ST_SHOW
  } scan_state_t;

  function automatic logic [3:0] coord_row(input logic [7:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] coord_col(input logic [7:0] c);
    return c[3:0];
  endfunction

  // Fields above 7 are off-matrix, so both row and column must have bit 3 clear.
  function automatic logic [7:0] coord_bit(input logic [7:0] c, input logic [2:0] row);
    logic [3:0] r;
    logic [3:0] k;
    r = coord_row(c);
    k = coord_col(c);
    if (r == {1'b0, row} && !k[3])
      return 8'b1 << k[2:0];
    return 8'h00;
  endfunction

  function automatic logic [7:0] overlay_pattern(input logic win, input logic over,
                                                 input logic start, input logic [2:0] row,
                                                 input logic [7:0] normal);
    if (win)
      return PAT_WIN;
    if (over)
      return (8'b1 << row) | (8'b1 << (3'd7 - row));
    if (start)
      return (row == 3'd0 || row == 3'd7) ? PAT_BORDER_EDGE : PAT_BORDER_SIDE;
    return normal;
  endfunction

endpackage

// File: rtl/snake_row_builder.sv
// rtl/snake_row_builder.sv - serial 11-step OR-accumulator producing one row bitmap
module snake_row_builder
  import snake_pkg::*;
(
  input  logic                   clkn,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   first,
  input  logic [2:0]             row,
  input  logic [3:0]             idx,
  input  logic [N_SEG-1:0][7:0]  seg,
  input  logic [7:0]             food,
  input  logic [3:0]             len,
  input  logic                   food_vis,
  output logic [7:0]             bitmap
);

  logic [7:0] acc;
  logic [7:0] term;

  always_comb begin
    term = 8'h00;
    for (int i = 0; i < N_SEG; i++) begin
      if (idx == 4'(i) && 4'(i) < len)
        term = coord_bit(seg[i], row);
    end
    if (idx == 4'(N_SEG) && food_vis)
      term = coord_bit(food, row);
    // Step 0 starts from an empty row so the previous row never leaks in.
    bitmap = (first ? 8'h00 : acc) | term;
  end

  always_ff @(posedge clkn or posedge reset) begin
    if (reset)
      acc <= 8'h00;
    else if (step)
      acc <= bitmap;
  end

endmodule

// File: rtl/snake_matrix_scan.sv
// rtl/snake_matrix_scan.sv - frame-snapshotting row-scan driver for the 8x8 snake LED matrix
module snake_matrix_scan
  import snake_pkg::*;
#(
  parameter int ROW_TICKS       = 1000,
  parameter int FOOD_BLINK_LOG2 = 4
) (
  input  logic       clkn,
  input  logic       reset,
  input  logic       display,
  input  logic       draw_start,
  input  logic       draw_over,
  input  logic       draw_win,
  input  logic [4:0] snake_len,
  input  logic [7:0] snake_0,
  input  logic [7:0] snake_1,
  input  logic [7:0] snake_2,
  input  logic [7:0] snake_3,
  input  logic [7:0] snake_4,
  input  logic [7:0] snake_5,
  input  logic [7:0] snake_6,
  input  logic [7:0] snake_7,
  input  logic [7:0] snake_8,
  input  logic [7:0] snake_9,
  input  logic [7:0] food,
  output logic [7:0] row_n,
  output logic [7:0] col,
  output logic       frame_done
);

  localparam int CW = $clog2(ROW_TICKS);
  localparam int FW = FOOD_BLINK_LOG2 + 1;

  scan_state_t          state, state_next;
  logic [CW-1:0]        cnt;
  logic [2:0]           row;
  logic [FW-1:0]        frame_cnt;

  logic [3:0]           len_s;
  logic [N_SEG-1:0][7:0] seg_s;
  logic [N_SEG-1:0][7:0] seg_in;
  logic [7:0]           food_s;
  logic                 win_s, over_s, start_s, disp_s;

  logic                 build_last, show_last, frame_last;
  logic [7:0]           bitmap;
  logic [7:0]           row_n_next, col_next;
  logic                 frame_done_next;

  assign seg_in = {snake_9, snake_8, snake_7, snake_6, snake_5,
                   snake_4, snake_3, snake_2, snake_1, snake_0};

  assign build_last = (state == ST_BUILD) && (cnt == CW'(BUILD_STEPS - 1));
  assign show_last  = (state == ST_SHOW) && (cnt == CW'(ROW_TICKS - 1));
  assign frame_last = show_last && (row == 3'd7);

  snake_row_builder u_builder (
    .clkn     (clkn),
    .reset    (reset),
    .step     (state == ST_BUILD),
    .first    (cnt == '0),
    .row      (row),
    .idx      (cnt[3:0]),
    .seg      (seg_s),
    .food     (food_s),
    .len      (len_s),
    .food_vis (~frame_cnt[FW-1]),
    .bitmap   (bitmap)
  );

  always_comb begin
    state_next      = state;
    row_n_next      = row_n;
    col_next        = col;
    frame_done_next = 1'b0;
    case (state)
      ST_SNAP:  state_next = ST_BUILD;
      ST_BUILD: if (build_last) state_next = ST_SHOW;
      ST_SHOW:  if (show_last) state_next = (row == 3'd7) ? ST_SNAP : ST_BUILD;
      default:  state_next = ST_SNAP;
    endcase
    // Outputs are loaded alongside the final accumulate step so SHOW opens with valid data.
    if (build_last && disp_s) begin
      row_n_next = ~(8'b1 << row);
      col_next   = overlay_pattern(win_s, over_s, start_s, row, bitmap);
    end
    if (show_last) begin
      row_n_next      = 8'hFF;
      col_next        = 8'h00;
      frame_done_next = (row == 3'd7);
    end
  end

  always_ff @(posedge clkn or posedge reset) begin
    if (reset) begin
      state      <= ST_SNAP;
      cnt        <= '0;
      row        <= 3'd0;
      frame_cnt  <= '0;
      row_n      <= 8'hFF;
      col        <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= (state_next != state) ? '0 : cnt + 1'b1;
      row_n      <= row_n_next;
      col        <= col_next;
      frame_done <= frame_done_next;
      if (state == ST_SNAP)
        row <= 3'd0;
      else if (show_last && row != 3'd7)
        row <= row + 3'd1;
      if (frame_last)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkn or posedge reset) begin
    if (reset) begin
      len_s   <= 4'd0;
      seg_s   <= '0;
      food_s  <= 8'h00;
      win_s   <= 1'b0;
      over_s  <= 1'b0;
      start_s <= 1'b0;
      disp_s  <= 1'b0;
    end else if (state == ST_SNAP) begin
      len_s   <= (snake_len > 5'd10) ? 4'd10 : snake_len[3:0];
      seg_s   <= seg_in;
      food_s  <= food;
      win_s   <= draw_win;
      over_s  <= draw_over;
      start_s <= draw_start;
      disp_s  <= display;
    end
  end

endmodule

// File: tb/tb_snake_matrix_scan.sv
// tb/tb_snake_matrix_scan.sv - scoreboard bench for snake_matrix_scan with ROW_TICKS = 20
module tb_snake_matrix_scan;

  localparam int ROW_TICKS = 20;
  localparam int ROW_P     = 11 + ROW_TICKS;
  localparam int FRAME_P   = 1 + 8 * ROW_P;

  logic       clkn = 1'b0;
  logic       reset = 1'b1;
  logic       display, draw_start, draw_over, draw_win;
  logic [4:0] snake_len;
  logic [7:0] snake [10];
  logic [7:0] food;
  logic [7:0] row_n, col;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  snake_matrix_scan #(.ROW_TICKS(ROW_TICKS), .FOOD_BLINK_LOG2(4)) dut (
    .clkn(clkn), .reset(reset), .display(display),
    .draw_start(draw_start), .draw_over(draw_over), .draw_win(draw_win),
    .snake_len(snake_len),
    .snake_0(snake[0]), .snake_1(snake[1]), .snake_2(snake[2]), .snake_3(snake[3]),
    .snake_4(snake[4]), .snake_5(snake[5]), .snake_6(snake[6]), .snake_7(snake[7]),
    .snake_8(snake[8]), .snake_9(snake[9]),
    .food(food), .row_n(row_n), .col(col), .frame_done(frame_done)
  );

  always #5 clkn = ~clkn;

  always @(posedge clkn or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc=%0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: frame position derived from edges since reset release.
  int p_mon;
  logic [15:0] exp_mon;
  always @(negedge clkn) begin
    if (!reset && cyc > 0) begin
      p_mon = cyc % FRAME_P;
      if (p_mon == 0) begin
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
      end else if (p_mon == 1) begin
        chk("frame_done_clear", {31'd0, frame_done}, 32'd0);
        chk("snap_blank", {16'd0, row_n, col}, {16'd0, 8'hFF, 8'h00});
      end else if (p_mon >= 12 && (p_mon - 12) % ROW_P == 0 && p_mon <= 12 + 7 * ROW_P) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL row_scan_underflow got=%h exp=none", {row_n, col});
        end else begin
          exp_mon = exp_q.pop_front();
          chk($sformatf("row_scan r%0d", (p_mon - 12) / ROW_P), {16'd0, row_n, col}, {16'd0, exp_mon});
        end
      end
    end
  end

  task automatic push_frame(input logic disp, input logic [63:0] cols);
    logic [7:0] rn;
    for (int r = 0; r < 8; r++) begin
      rn = ~(8'b1 << r);
      exp_q.push_back(disp ? {rn, cols[8*r +: 8]} : 16'hFF00);
    end
  endtask

  task automatic set_basic();
    snake_len = 5'd3;
    snake[0] = 8'h22;
    snake[1] = 8'h23;
    snake[2] = 8'h24;
    food = 8'h55;
  endtask

  task automatic set_frame(input int f);
    display = 1'b1; draw_start = 1'b0; draw_over = 1'b0; draw_win = 1'b0;
    snake_len = 5'd0;
    for (int i = 0; i < 10; i++) snake[i] = 8'h88;
    food = 8'h88;
    case (f)
      0: begin set_basic(); display = 1'b0; push_frame(1'b0, 64'h0); end
      2: begin set_basic(); snake_len = 5'd2; push_frame(1'b1, 64'h0000_2000_000C_0000); end
      3: begin
        snake_len = 5'd31; food = 8'h55;
        snake[0] = 8'h00; snake[1] = 8'h11; snake[2] = 8'h22; snake[3] = 8'h33; snake[4] = 8'h44;
        snake[5] = 8'h55; snake[6] = 8'h66; snake[7] = 8'h77; snake[8] = 8'h70; snake[9] = 8'h07;
        push_frame(1'b1, 64'h8140_2010_0804_0281);
      end
      4: begin snake_len = 5'd3; snake[0] = 8'h88; snake[1] = 8'h38; snake[2] = 8'h83;
               push_frame(1'b1, 64'h0); end
      5: begin set_basic(); draw_over = 1'b1; draw_win = 1'b1; push_frame(1'b1, 64'hFFFF_FFFF_FFFF_FFFF); end
      6: begin set_basic(); draw_over = 1'b1; push_frame(1'b1, 64'h8142_2418_1824_4281); end
      7: begin set_basic(); draw_start = 1'b1; push_frame(1'b1, 64'hFF81_8181_8181_81FF); end
      8: begin snake_len = 5'd1; snake[0] = 8'h00; push_frame(1'b1, 64'h0000_0000_0000_0001); end
      9: begin snake_len = 5'd1; snake[0] = 8'h70; push_frame(1'b1, 64'h0100_0000_0000_0000); end
      10: begin set_basic(); display = 1'b0; draw_win = 1'b1; push_frame(1'b0, 64'h0); end
      default: begin
        set_basic();
        push_frame(1'b1, (f < 16) ? 64'h0000_2000_001C_0000 : 64'h0000_0000_001C_0000);
      end
    endcase
  endtask

  task automatic wait_cyc(input int target);
    int budget;
    budget = 20000;
    while (cyc != target && budget > 0) begin
      @(negedge clkn);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout got=%0d exp=%0d", cyc, target);
    end
  endtask

  initial begin
    display = 1'b0; draw_start = 1'b0; draw_over = 1'b0; draw_win = 1'b0;
    snake_len = 5'd0; food = 8'h88;
    for (int i = 0; i < 10; i++) snake[i] = 8'h88;
    repeat (3) @(negedge clkn);
    chk("reset_row_n", {24'd0, row_n}, 32'hFF);
    chk("reset_col", {24'd0, col}, 32'h00);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);

    set_frame(0);
    reset = 1'b0;
    for (int f = 1; f <= 18; f++) begin
      wait_cyc(FRAME_P * f);
      set_frame(f);
      if (f == 8) begin
        wait_cyc(FRAME_P * 8 + 12 + 4 * ROW_P + 5);
        snake[0] = 8'h70;
      end
    end

    // Frame 18: reset while row 5 is lit.
    wait_cyc(FRAME_P * 18 + 12 + 5 * ROW_P + 3);
    chk("pre_reset_row_n", {24'd0, row_n}, 32'hDF);
    @(posedge clkn);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_row_n", {24'd0, row_n}, 32'hFF);
    chk("async_reset_col", {24'd0, col}, 32'h00);
    chk("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(posedge clkn);
    @(negedge clkn);
    exp_q.delete();
    set_frame(1);
    reset = 1'b0;
    wait_cyc(FRAME_P + 1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
